// File: rtl/core_pkg.sv
// Shared core definitions for the RV64 front end: datapath width, instruction size,
// fetch FSM encoding and the alignment helper.
package core_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    // Without the compressed ISA, every fetch target must be 4-byte aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and keeps one instruction-memory request in flight.
// It hands returned instructions to decode and applies execute-qualified redirects.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic            req_fire_s;
    logic            bad_redirect_s;

    // Request and decode-valid depend on registered state only, never on inputs.
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == ST_HOLD);
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign fetch_fault    = fault_q;
    assign fault_pc       = fault_pc_q;

    assign req_fire_s     = (state_q == ST_REQ) && imem_req_ready;
    assign bad_redirect_s = redirect_valid && is_misaligned(redirect_pc);

    // Next-state and datapath updates; a misaligned redirect overrides every other transition.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        if (state_q == ST_FAULT) begin
            state_d = ST_FAULT;
        end else if (bad_redirect_s) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        // An accepted stale request still owes a response that must be drained.
                        state_d = req_fire_s ? ST_DRAIN : ST_REQ;
                    end else if (req_fire_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = imem_resp_valid ? ST_REQ : ST_DRAIN;
                    end else if (imem_resp_valid) begin
                        if_instr_d = imem_resp_data;
                        if_pc_d    = pc_q;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = ST_REQ;
                    end else if (if_ready) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        pc_d = pc_q;
                    end
                    state_d = imem_resp_valid ? ST_REQ : ST_DRAIN;
                end
                default: begin
                    state_d = ST_REQ;
                    pc_d    = RESET_PC;
                end
            endcase
        end
    end

    // State, PC and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            if_instr_q <= 32'h0;
            if_pc_q    <= 64'h0;
            fault_q    <= 1'b0;
            fault_pc_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

endmodule
